serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder sequencer. A single full_adder cell adds two N-bit operands
// LSB first, one bit per clock. The block holds the operand shift registers,
// the carry flop and the bit counter, and exposes a start/busy/done handshake.
//
// Handshake: start is sampled only while ready=1 (IDLE). The accepting edge
// captures a, b and c_in. done is a one-cycle pulse during which sum/c_out are
// valid; both then hold until the next accepted start. start while busy or in
// DONE is ignored (no queuing).
//
// Optional feature (macro SERIAL_ADDER_OVF_EN): adds the overflow port, the
// signed-overflow flag of the last add, held alongside sum.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active high
//   start     in   add request
//   a, b      in   N-bit operands
//   c_in      in   carry-in
//   ready     out  high in IDLE
//   busy      out  high in RUN
//   done      out  one-cycle result-valid pulse
//   sum       out  N-bit result
//   c_out     out  final carry
//   overflow  out  signed overflow (SERIAL_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c_in;
    assign carry = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic         overflow,
`endif
    output logic         c_out
);
    // Counter needs at least one bit so that N=1 still has a legal vector.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_sh_q, a_sh_d;
    logic [N-1:0]    b_sh_q, b_sh_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            c_out_q, c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic            fa_sum;
    logic            fa_carry;
    logic [N-1:0]    sum_msb_ins;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Sum bit destined for position N-1; built as a vector so N=1 needs no
    // special-cased slice.
    always_comb begin
        sum_msb_ins        = '0;
        sum_msb_ins[N-1]   = fa_sum;
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                sum_d   = (sum_q >> 1) | sum_msb_ins;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    c_out_d = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into bit N-1, fa_carry the carry out.
                    ovf_d   = carry_q ^ fa_carry;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign overflow = ovf_q;
`endif

endmodule
